// File: rtl/display_scheduler.sv
// Shares one 4-digit seven-segment display between total-steps, steps-per-minute
// and GPS views, with manual or auto-rotating selection and a dark gap on every source change.
module display_scheduler #(
  parameter int DWELL_CYCLES = 300_000_000,
  parameter int BLANK_CYCLES = 1_000_000,
  parameter int CNT_W        = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       auto_en,
  input  logic [1:0] man_sel,
  input  logic       gps_valid,
  input  logic [3:0] an_step,
  input  logic [6:0] seg_step,
  input  logic [3:0] an_gps,
  input  logic [6:0] seg_gps,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       step_view,
  output logic [1:0] cur_src,
  output logic       switching
);

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

  localparam logic [1:0]       SRC_TOTAL  = 2'd0;
  localparam logic [1:0]       SRC_SPM    = 2'd1;
  localparam logic [1:0]       SRC_GPS    = 2'd2;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             auto_meta_q, auto_sync_q;
  logic [1:0]       man_meta_q, man_sync_q;
  logic             gps_meta_q, gps_sync_q;

  state_e           state_q, state_d;
  logic [1:0]       cur_src_q, cur_src_d;
  logic             step_view_q, step_view_d;
  logic             switching_q, switching_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] blank_q, blank_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic [1:0]       man_tgt_s;
  logic [1:0]       auto_next_s;
  logic [1:0]       target_s;
  logic             dwell_exp_s;

  // Two-flop synchronizers for the asynchronous switches and GPS status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      auto_meta_q <= 1'b0;
      auto_sync_q <= 1'b0;
      man_meta_q  <= 2'b00;
      man_sync_q  <= 2'b00;
      gps_meta_q  <= 1'b0;
      gps_sync_q  <= 1'b0;
    end else begin
      auto_meta_q <= auto_en;
      auto_sync_q <= auto_meta_q;
      man_meta_q  <= man_sel;
      man_sync_q  <= man_meta_q;
      gps_meta_q  <= gps_valid;
      gps_sync_q  <= gps_meta_q;
    end
  end

  // Target view: manual decode, or auto rotation advancing on dwell expiry.
  always_comb begin
    man_tgt_s   = SRC_GPS;
    auto_next_s = SRC_TOTAL;
    target_s    = cur_src_q;
    dwell_exp_s = (state_q == ST_SHOW) && auto_sync_q && (dwell_q == DWELL_LAST);

    case (man_sync_q)
      2'b00:   man_tgt_s = SRC_TOTAL;
      2'b01:   man_tgt_s = SRC_SPM;
      default: man_tgt_s = SRC_GPS;
    endcase

    case (cur_src_q)
      SRC_TOTAL: auto_next_s = SRC_SPM;
      SRC_SPM:   auto_next_s = gps_sync_q ? SRC_GPS : SRC_TOTAL;
      default:   auto_next_s = SRC_TOTAL;
    endcase

    // Losing GPS while it is on screen in auto mode drops back to view 0 at once.
    if (!auto_sync_q) begin
      target_s = man_tgt_s;
    end else if (dwell_exp_s) begin
      target_s = auto_next_s;
    end else if ((cur_src_q == SRC_GPS) && !gps_sync_q) begin
      target_s = SRC_TOTAL;
    end else begin
      target_s = cur_src_q;
    end
  end

  // SHOW/BLANK sequencing with dwell and blank counters.
  always_comb begin
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    step_view_d = step_view_q;
    dwell_d     = CNT_ZERO;
    blank_d     = CNT_ZERO;

    case (state_q)
      ST_SHOW: begin
        if (target_s != cur_src_q) begin
          state_d     = ST_BLANK;
          cur_src_d   = target_s;
          step_view_d = (target_s == SRC_SPM);
        end else if (auto_sync_q && !dwell_exp_s) begin
          dwell_d = dwell_q + CNT_ONE;
        end else begin
          dwell_d = CNT_ZERO;
        end
      end
      ST_BLANK: begin
        // Target changes seen mid-blank are picked up on the first SHOW cycle.
        if (blank_q == BLANK_LAST) begin
          state_d = ST_SHOW;
        end else begin
          blank_d = blank_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_SHOW;
      end
    endcase

    switching_d = (state_d == ST_BLANK);
  end

  // Display mux, registered one cycle behind the state register.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    if (state_q == ST_SHOW) begin
      if (cur_src_q == SRC_GPS) begin
        an_d  = an_gps;
        seg_d = seg_gps;
      end else begin
        an_d  = an_step;
        seg_d = seg_step;
      end
    end else begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SHOW;
      cur_src_q   <= SRC_TOTAL;
      step_view_q <= 1'b0;
      switching_q <= 1'b0;
      dwell_q     <= CNT_ZERO;
      blank_q     <= CNT_ZERO;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      step_view_q <= step_view_d;
      switching_q <= switching_d;
      dwell_q     <= dwell_d;
      blank_q     <= blank_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign step_view = step_view_q;
  assign cur_src   = cur_src_q;
  assign switching = switching_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with DWELL_CYCLES=8 and BLANK_CYCLES=3.
module tb_display_scheduler;

  localparam logic [3:0] AN_S  = 4'b1110;
  localparam logic [6:0] SEG_S = 7'b0100100;
  localparam logic [3:0] AN_G  = 4'b0111;
  localparam logic [6:0] SEG_G = 7'b0001000;
  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic       auto_en;
  logic [1:0] man_sel;
  logic       gps_valid;
  logic [3:0] an_step, an_gps;
  logic [6:0] seg_step, seg_gps;
  logic [3:0] an;
  logic [6:0] seg;
  logic       step_view;
  logic [1:0] cur_src;
  logic       switching;

  int n_checks = 0;
  int n_fail   = 0;

  display_scheduler #(
    .DWELL_CYCLES(8),
    .BLANK_CYCLES(3),
    .CNT_W(29)
  ) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .man_sel(man_sel), .gps_valid(gps_valid),
    .an_step(an_step), .seg_step(seg_step), .an_gps(an_gps), .seg_gps(seg_gps),
    .an(an), .seg(seg), .step_view(step_view), .cur_src(cur_src), .switching(switching)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the edge where switching rises; walks one full blank+show period (11 edges).
  task automatic check_view(input logic [1:0] src, input logic [3:0] ea, input logic [6:0] es);
    chk("view_enter_sw", {31'd0, switching}, 32'd1);
    chk("view_enter_src", {30'd0, cur_src}, {30'd0, src});
    chk("view_step_view", {31'd0, step_view}, {31'd0, (src == 2'd1)});
    tick();
    chk("view_blank_an", {28'd0, an}, {28'd0, AN_OFF});
    chk("view_blank_seg", {25'd0, seg}, {25'd0, SEG_OFF});
    tick();
    tick();
    chk("view_blank_end_sw", {31'd0, switching}, 32'd0);
    chk("view_blank_end_an", {28'd0, an}, {28'd0, AN_OFF});
    tick();
    chk("view_show_an", {28'd0, an}, {28'd0, ea});
    chk("view_show_seg", {25'd0, seg}, {25'd0, es});
    repeat (6) tick();
    chk("view_last_show_sw", {31'd0, switching}, 32'd0);
    chk("view_last_show_an", {28'd0, an}, {28'd0, ea});
    chk("view_last_show_src", {30'd0, cur_src}, {30'd0, src});
    tick();
  endtask

  initial begin
    an_step  = AN_S;
    seg_step = SEG_S;
    an_gps   = AN_G;
    seg_gps  = SEG_G;
    rst       = 1'b0;
    auto_en   = 1'($urandom_range(1, 0));
    man_sel   = 2'($urandom_range(3, 0));
    gps_valid = 1'($urandom_range(1, 0));
    tick();
    tick();

    // 1. reset values
    chk("rst_an", {28'd0, an}, {28'd0, AN_OFF});
    chk("rst_seg", {25'd0, seg}, {25'd0, SEG_OFF});
    chk("rst_cur_src", {30'd0, cur_src}, 32'd0);
    chk("rst_step_view", {31'd0, step_view}, 32'd0);
    chk("rst_switching", {31'd0, switching}, 32'd0);
    auto_en   = 1'b0;
    man_sel   = 2'b00;
    gps_valid = 1'b1;
    rst       = 1'b1;
    tick();
    chk("first_show_an", {28'd0, an}, {28'd0, AN_S});
    chk("first_show_seg", {25'd0, seg}, {25'd0, SEG_S});

    // 2. manual 00 -> 01
    man_sel = 2'b01;
    tick();
    tick();
    chk("man_t2_sw", {31'd0, switching}, 32'd0);
    tick();
    chk("man_t3_sw", {31'd0, switching}, 32'd1);
    chk("man_t3_step_view", {31'd0, step_view}, 32'd1);
    chk("man_t3_src", {30'd0, cur_src}, 32'd1);
    chk("man_t3_an", {28'd0, an}, {28'd0, AN_S});
    tick();
    chk("man_t4_an", {28'd0, an}, {28'd0, AN_OFF});
    chk("man_t4_seg", {25'd0, seg}, {25'd0, SEG_OFF});
    tick();
    chk("man_t5_an", {28'd0, an}, {28'd0, AN_OFF});
    chk("man_t5_sw", {31'd0, switching}, 32'd1);
    tick();
    chk("man_t6_an", {28'd0, an}, {28'd0, AN_OFF});
    chk("man_t6_sw", {31'd0, switching}, 32'd0);
    tick();
    chk("man_t7_an", {28'd0, an}, {28'd0, AN_S});
    chk("man_t7_sw", {31'd0, switching}, 32'd0);

    man_sel = 2'b00;
    repeat (8) tick();
    chk("back_to_total_src", {30'd0, cur_src}, 32'd0);
    chk("back_to_total_sw", {31'd0, switching}, 32'd0);

    // 3. auto rotation with GPS valid
    auto_en = 1'b1;
    repeat (9) tick();
    chk("auto_first_dwell_sw", {31'd0, switching}, 32'd0);
    chk("auto_first_dwell_src", {30'd0, cur_src}, 32'd0);
    tick();
    check_view(2'd1, AN_S, SEG_S);
    check_view(2'd2, AN_G, SEG_G);
    check_view(2'd0, AN_S, SEG_S);

    // 4. auto rotation without GPS
    gps_valid = 1'b0;
    check_view(2'd1, AN_S, SEG_S);
    check_view(2'd0, AN_S, SEG_S);
    check_view(2'd1, AN_S, SEG_S);
    check_view(2'd0, AN_S, SEG_S);

    // 5. GPS lost while showing GPS in auto mode
    gps_valid = 1'b1;
    check_view(2'd1, AN_S, SEG_S);
    chk("gps_enter_src", {30'd0, cur_src}, 32'd2);
    repeat (5) tick();
    chk("gps_mid_dwell_an", {28'd0, an}, {28'd0, AN_G});
    gps_valid = 1'b0;
    tick();
    tick();
    chk("gps_drop_t2_sw", {31'd0, switching}, 32'd0);
    chk("gps_drop_t2_src", {30'd0, cur_src}, 32'd2);
    tick();
    check_view(2'd0, AN_S, SEG_S);

    // 6a. manual toggle during BLANK
    auto_en = 1'b0;
    man_sel = 2'b01;
    repeat (6) tick();
    chk("man_settle_sw", {31'd0, switching}, 32'd0);
    chk("man_settle_src", {30'd0, cur_src}, 32'd1);
    man_sel = 2'b00;
    repeat (3) tick();
    chk("toggle_t3_sw", {31'd0, switching}, 32'd1);
    chk("toggle_t3_src", {30'd0, cur_src}, 32'd0);
    man_sel = 2'b01;
    repeat (3) tick();
    chk("toggle_t6_sw", {31'd0, switching}, 32'd0);
    chk("toggle_t6_src", {30'd0, cur_src}, 32'd0);
    tick();
    chk("toggle_t7_sw", {31'd0, switching}, 32'd1);
    chk("toggle_t7_src", {30'd0, cur_src}, 32'd1);
    chk("toggle_t7_step_view", {31'd0, step_view}, 32'd1);
    chk("toggle_t7_an", {28'd0, an}, {28'd0, AN_S});
    tick();
    chk("toggle_t8_an", {28'd0, an}, {28'd0, AN_OFF});
    tick();
    chk("toggle_t9_sw", {31'd0, switching}, 32'd1);
    tick();
    chk("toggle_t10_sw", {31'd0, switching}, 32'd0);
    chk("toggle_t10_an", {28'd0, an}, {28'd0, AN_OFF});
    tick();
    chk("toggle_t11_an", {28'd0, an}, {28'd0, AN_S});

    // 6b. reset pulse mid-dwell
    auto_en = 1'b1;
    repeat (6) tick();
    rst = 1'b0;
    #1;
    chk("midrst_an", {28'd0, an}, {28'd0, AN_OFF});
    chk("midrst_seg", {25'd0, seg}, {25'd0, SEG_OFF});
    chk("midrst_src", {30'd0, cur_src}, 32'd0);
    chk("midrst_step_view", {31'd0, step_view}, 32'd0);
    chk("midrst_sw", {31'd0, switching}, 32'd0);
    tick();
    rst = 1'b1;
    repeat (9) tick();
    chk("redwell_r9_sw", {31'd0, switching}, 32'd0);
    chk("redwell_r9_src", {30'd0, cur_src}, 32'd0);
    chk("redwell_r9_an", {28'd0, an}, {28'd0, AN_S});
    tick();
    chk("redwell_r10_sw", {31'd0, switching}, 32'd1);
    chk("redwell_r10_src", {30'd0, cur_src}, 32'd1);

    // manual GPS selection (11) with GPS invalid still shows GPS path
    auto_en = 1'b0;
    man_sel = 2'b11;
    repeat (4) tick();
    chk("mangps_sw", {31'd0, switching}, 32'd1);
    chk("mangps_src", {30'd0, cur_src}, 32'd2);
    repeat (4) tick();
    chk("mangps_an", {28'd0, an}, {28'd0, AN_G});
    chk("mangps_seg", {25'd0, seg}, {25'd0, SEG_G});
    repeat (2) tick();
    chk("mangps_hold_src", {30'd0, cur_src}, 32'd2);
    chk("mangps_hold_sw", {31'd0, switching}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
